// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: parses a {sync|fun, A, B} byte frame, fires one ALU op,
// and returns the 16-bit result LSB-first over a valid/ready byte stream.
//
// state    | meaning
// IDLE     | waiting for a command byte with the sync nibble
// GET_A    | waiting for operand A (byte timeout armed)
// GET_B    | waiting for operand B (byte timeout armed)
// EXEC     | o_alu_en pulse, operands stable
// WAIT_RES | waiting for i_alu_valid (result timeout armed)
// SEND_LO  | offering result[7:0]
// SEND_HI  | offering result[15:8]
module alu_cmd_ctrl #(
    parameter int         OPER_WIDTH  = 8,
    parameter int         OUT_WIDTH   = 2*OPER_WIDTH,
    parameter logic [3:0] SYNC_NIB    = 4'hA,
    parameter int         TIMEOUT_CYC = 1024,
    parameter int         RES_TIMEOUT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [OPER_WIDTH-1:0] o_alu_a,
    output logic [OPER_WIDTH-1:0] o_alu_b,
    output logic [3:0]            o_alu_fun,
    output logic                  o_alu_en,
    input  logic [OUT_WIDTH-1:0]  i_alu_out,
    input  logic                  i_alu_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_overrun
);

    localparam int CNT_MAX = (TIMEOUT_CYC > RES_TIMEOUT) ? TIMEOUT_CYC : RES_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] BYTE_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] RES_LOAD  = CNT_W'(RES_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_WAIT_RES, S_SEND_LO, S_SEND_HI
    } state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [OUT_WIDTH-1:0]    result, result_nx;
    logic [OPER_WIDTH-1:0]   a_nx, b_nx;
    logic [3:0]              fun_nx;
    logic [7:0]              tx_data_nx;
    logic                    en_nx, tx_valid_nx, busy_nx, err_nx, ovr_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            result      <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            o_alu_fun   <= '0;
            o_alu_en    <= 1'b0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            result      <= result_nx;
            o_alu_a     <= a_nx;
            o_alu_b     <= b_nx;
            o_alu_fun   <= fun_nx;
            o_alu_en    <= en_nx;
            o_tx_data   <= tx_data_nx;
            o_tx_valid  <= tx_valid_nx;
            o_busy      <= busy_nx;
            o_frame_err <= err_nx;
            o_overrun   <= ovr_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        result_nx  = result;
        a_nx       = o_alu_a;
        b_nx       = o_alu_b;
        fun_nx     = o_alu_fun;
        tx_data_nx = o_tx_data;
        en_nx      = 1'b0;
        err_nx     = 1'b0;
        ovr_nx     = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data[7:4] == SYNC_NIB) begin
                        fun_nx   = i_rx_data[3:0];
                        cnt_nx   = BYTE_LOAD;
                        state_nx = S_GET_A;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            // A byte on the terminal-count cycle is still accepted.
            S_GET_A: begin
                if (i_rx_valid) begin
                    a_nx     = i_rx_data[OPER_WIDTH-1:0];
                    cnt_nx   = BYTE_LOAD;
                    state_nx = S_GET_B;
                end else if (cnt == '0) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_GET_B: begin
                if (i_rx_valid) begin
                    b_nx     = i_rx_data[OPER_WIDTH-1:0];
                    en_nx    = 1'b1;
                    state_nx = S_EXEC;
                end else if (cnt == '0) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_EXEC: begin
                ovr_nx   = i_rx_valid;
                cnt_nx   = RES_LOAD;
                state_nx = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                ovr_nx = i_rx_valid;
                if (i_alu_valid) begin
                    result_nx  = i_alu_out;
                    tx_data_nx = i_alu_out[7:0];
                    state_nx   = S_SEND_LO;
                end else if (cnt == '0) begin
                    err_nx   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_SEND_LO: begin
                ovr_nx = i_rx_valid;
                if (i_tx_ready) begin
                    tx_data_nx = result[OUT_WIDTH-1:OPER_WIDTH];
                    state_nx   = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                ovr_nx = i_rx_valid;
                if (i_tx_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        tx_valid_nx = (state_nx == S_SEND_LO) || (state_nx == S_SEND_HI);
        busy_nx     = (state_nx != S_IDLE);
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a 1-cycle-latency ALU model and a TX byte collector.
module tb_alu_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out = '0;
    logic        alu_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy, frame_err, overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  = 0;
    int   err_cnt = 0;
    int   ovr_cnt = 0;
    bit   alu_mute = 1'b0;
    logic [7:0] txq[$];

    alu_cmd_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_fun   (alu_fun),
        .o_alu_en    (alu_en),
        .i_alu_out   (alu_out),
        .i_alu_valid (alu_valid),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_frame_err (frame_err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    // ALU model: registered result one cycle after en; mute suppresses valid.
    always @(posedge clk) begin
        alu_valid <= alu_en && !alu_mute;
        if (alu_en) begin
            case (alu_fun)
                4'd0:    alu_out <= {8'h00, alu_a} + {8'h00, alu_b};
                4'd1:    alu_out <= {8'h00, alu_a} - {8'h00, alu_b};
                4'd2:    alu_out <= alu_a * alu_b;
                default: alu_out <= {8'h00, alu_a & alu_b};
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
        if (alu_en)    en_cnt++;
        if (frame_err) err_cnt++;
        if (overrun)   ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        int i = 0;
        while (txq.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_txcnt"}, txq.size(), n);
    endtask

    function automatic logic [31:0] txb(input int i);
        return (i < txq.size()) ? {24'h0, txq[i]} : 32'hDEAD;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ab"},   {alu_a, alu_b}, 32'h0);
        chk({tag, "_ctl"},  {alu_fun, alu_en, tx_data, tx_valid, frame_err, overrun}, 32'h0);
        chk({tag, "_busy"}, busy, 32'h0);
    endtask

    initial begin
        int e0, f0, o0, bad;
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;

        // Reset with random input activity
        repeat (2) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'($urandom);
            tx_ready = 1'($urandom);
            @(negedge clk);
        end
        chk_zero("rst");
        rst      = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        tick(1);

        // ADD with exact latency
        txq.delete();
        e0 = en_cnt;
        send_byte(8'hA0);
        send_byte(8'h05);
        send_byte(8'h03);
        chk("add_en", alu_en, 1);
        chk("add_ops", {alu_fun, alu_a, alu_b}, {12'h0, 4'h0, 8'h05, 8'h03});
        tick(1);
        chk("add_en_off", alu_en, 0);
        chk("add_txv_n2", tx_valid, 0);
        tick(1);
        chk("add_txv_n3", tx_valid, 1);
        chk("add_lo_now", tx_data, 8'h08);
        wait_tx("add", 2, 10);
        chk("add_txv_done", tx_valid, 0);
        chk("add_b0", txb(0), 8'h08);
        chk("add_b1", txb(1), 8'h00);
        chk("add_en_cnt", en_cnt - e0, 1);

        // MUL under backpressure
        tx_ready = 1'b0;
        txq.delete();
        send_byte(8'hA2);
        send_byte(8'hFF);
        send_byte(8'hFF);
        tick(2);
        chk("mul_txv", tx_valid, 1);
        chk("mul_lo", tx_data, 8'h01);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === 8'h01)) bad++;
        end
        chk("mul_hold", bad, 0);
        tx_ready = 1'b1;
        wait_tx("mul", 2, 10);
        tick(4);
        chk("mul_exact", txq.size(), 2);
        chk("mul_b0", txb(0), 8'h01);
        chk("mul_b1", txb(1), 8'hFE);

        // Bad sync byte
        e0 = en_cnt;
        f0 = err_cnt;
        send_byte(8'h55);
        chk("bad_err", frame_err, 1);
        chk("bad_busy", busy, 0);
        tick(2);
        chk("bad_err_cnt", err_cnt - f0, 1);
        chk("bad_no_en", en_cnt - e0, 0);

        // Overrun during WAIT_RES
        txq.delete();
        o0 = ovr_cnt;
        send_byte(8'hA0);
        send_byte(8'h10);
        send_byte(8'h20);
        tick(1);
        send_byte(8'h77);
        chk("ovr_pulse", overrun, 1);
        wait_tx("ovr", 2, 10);
        chk("ovr_b0", txb(0), 8'h30);
        chk("ovr_b1", txb(1), 8'h00);
        chk("ovr_cnt", ovr_cnt - o0, 1);
        chk("ovr_busy", busy, 0);

        // Byte timeout after A
        send_byte(8'hA1);
        send_byte(8'h10);
        tick(1023);
        chk("bto_early", frame_err, 0);
        chk("bto_busy", busy, 1);
        tick(1);
        chk("bto_err", frame_err, 1);
        chk("bto_idle", busy, 0);

        // Result timeout
        alu_mute = 1'b1;
        txq.delete();
        send_byte(8'hA0);
        send_byte(8'h01);
        send_byte(8'h02);
        tick(4);
        chk("rto_early", frame_err, 0);
        chk("rto_busy", busy, 1);
        tick(1);
        chk("rto_err", frame_err, 1);
        chk("rto_idle", busy, 0);
        tick(3);
        chk("rto_nosend", txq.size(), 0);
        alu_mute = 1'b0;
        send_byte(8'hA1);
        send_byte(8'h09);
        send_byte(8'h04);
        wait_tx("sub", 2, 10);
        chk("sub_b0", txb(0), 8'h05);
        chk("sub_b1", txb(1), 8'h00);

        // Reset while offering the high byte
        tx_ready = 1'b0;
        txq.delete();
        send_byte(8'hA2);
        send_byte(8'h12);
        send_byte(8'h34);
        tick(2);
        chk("rsend_lo", {tx_valid, tx_data}, {1'b1, 8'hA8});
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        chk("rsend_hi", {tx_valid, tx_data}, {1'b1, 8'h03});
        rst = 1'b1;
        tick(1);
        chk_zero("rsend");
        rst      = 1'b0;
        tx_ready = 1'b1;
        tick(1);
        txq.delete();
        send_byte(8'hA0);
        send_byte(8'h01);
        send_byte(8'h01);
        wait_tx("post", 2, 10);
        chk("post_b0", txb(0), 8'h02);
        chk("post_b1", txb(1), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
